// File: rtl/gerador_sequencia.sv
// gerador_sequencia: LFSR word generator that writes num_palavras pseudo-random LED words to memory.
// Optional macro GERADOR_CODIGO_VALIDO_EN maps reserved 2'b11 LED codes in Entrada to 2'b00.
module gerador_sequencia #(
  parameter int bits_palavra  = 64,
  parameter int end_registros = 10,
  parameter int PASSOS        = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     iniciar,
  input  logic [31:0]              semente,
  input  logic [end_registros-1:0] num_palavras,
  output logic                     Hab_Escrita,
  output logic [end_registros-1:0] endereco,
  output logic [bits_palavra-1:0]  Entrada,
  output logic                     ocupado,
  output logic                     pronto
);
  typedef enum logic [2:0] {IDLE, SEED, GEN, WRITE, DONE} state_t;
  localparam logic [63:0] TAPS = 64'hD800_0000_0000_0000;
  localparam int PW = PASSOS > 1 ? $clog2(PASSOS) : 1;
  state_t state, state_nx;
  logic [63:0] lfsr, lfsr_step;
  logic [31:0] semente_q;
  logic [end_registros-1:0] num_q, ultimo;
  logic [PW-1:0] passo;
  logic ultimo_passo;
  function automatic logic [bits_palavra-1:0] filtro(input logic [63:0] v);
    logic [bits_palavra-1:0] w;
    w = v[bits_palavra-1:0];
`ifdef GERADOR_CODIGO_VALIDO_EN
    for (int i = 0; i < bits_palavra / 2; i++)
      if (w[2*i +: 2] == 2'b11) w[2*i +: 2] = 2'b00;
`endif
    return w;
  endfunction
  // a count of 0 wraps to all-ones, so the run covers the whole address space
  assign ultimo       = num_q - end_registros'(1);
  assign ultimo_passo = passo == PW'(PASSOS - 1);
  assign lfsr_step    = lfsr[0] ? (lfsr >> 1) ^ TAPS : lfsr >> 1;
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = iniciar ? SEED : IDLE;
      SEED:    state_nx = GEN;
      GEN:     state_nx = ultimo_passo ? WRITE : GEN;
      WRITE:   state_nx = endereco == ultimo ? DONE : GEN;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    Hab_Escrita = state == WRITE;
    ocupado     = state != IDLE;
    pronto      = state == DONE;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      lfsr      <= '0;
      semente_q <= '0;
      num_q     <= '0;
      passo     <= '0;
      endereco  <= '0;
      Entrada   <= '0;
    end else begin
      if (state == IDLE && iniciar) begin
        semente_q <= semente;
        num_q     <= num_palavras;
      end
      if (state == SEED) begin
        lfsr     <= {semente_q, ~semente_q};
        passo    <= '0;
        endereco <= '0;
      end
      if (state == GEN) begin
        lfsr  <= lfsr_step;
        passo <= ultimo_passo ? '0 : passo + PW'(1);
      end
      if (state == GEN && ultimo_passo) Entrada <= filtro(lfsr_step);
      if (state == WRITE && state_nx == GEN) endereco <= endereco + end_registros'(1);
    end
endmodule

// File: tb/tb_gerador_sequencia.sv
// tb_gerador_sequencia: cycle-level model of the word schedule and LFSR data, compared every cycle,
// plus directed runs with hand-computed timing and data literals.
module tb_gerador_sequencia;
  localparam int AW = 10, W = 64, P = 8, C = P + 1;
`ifdef GERADOR_CODIGO_VALIDO_EN
  localparam logic [63:0] W0_SEED1 = 64'h9120_0000_0100_0000;
`else
  localparam logic [63:0] W0_SEED1 = 64'h9120_0000_01FF_FFFF;
`endif
  logic clock = 0, reset = 0, iniciar = 0;
  logic [31:0] semente = '0;
  logic [AW-1:0] num_palavras = '0;
  logic Hab_Escrita, ocupado, pronto;
  logic [AW-1:0] endereco;
  logic [W-1:0] Entrada;
  int checks = 0, errors = 0;
  logic [63:0] cap[$], prev[$];
  bit zero_seen;
  always #5 clock = ~clock;
  gerador_sequencia #(.bits_palavra(W), .end_registros(AW), .PASSOS(P)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .semente(semente), .num_palavras(num_palavras),
    .Hab_Escrita(Hab_Escrita), .endereco(endereco), .Entrada(Entrada), .ocupado(ocupado), .pronto(pronto));
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask
  function automatic logic [63:0] step(input logic [63:0] v);
    for (int i = 0; i < P; i++) v = v[0] ? (v >> 1) ^ 64'hD800_0000_0000_0000 : v >> 1;
    return v;
  endfunction
  function automatic logic [63:0] filt(input logic [63:0] v);
`ifdef GERADOR_CODIGO_VALIDO_EN
    for (int i = 0; i < 32; i++) if (v[2*i +: 2] == 2'b11) v[2*i +: 2] = 2'b00;
`endif
    return v;
  endfunction
  // k counts cycles since acceptance: k=1 is the seed cycle, writes at k = C*j+1, pronto at C*n+2
  function automatic bit wr_at(input int k);
    return k > C && (k - 1) % C == 0;
  endfunction
  bit m_act = 0;
  int m_k = 0, m_n = 0;
  logic [63:0] m_lfsr = '0, m_data = '0;
  always @(posedge clock or negedge reset)
    if (!reset) begin
      m_act <= 0; m_k <= 0; m_n <= 0; m_lfsr <= '0; m_data <= '0;
    end else if (!m_act) begin
      if (iniciar) begin
        m_act  <= 1;
        m_k    <= 1;
        m_n    <= num_palavras == 0 ? 1 << AW : int'(num_palavras);
        m_lfsr <= {semente, ~semente};
      end
    end else if (m_k == C * m_n + 2) begin
      m_act <= 0; m_k <= 0;
    end else begin
      m_k <= m_k + 1;
      if (wr_at(m_k + 1)) begin
        m_lfsr <= step(m_lfsr);
        m_data <= filt(step(m_lfsr));
      end
    end
  always @(negedge clock) begin
    chk("hab_escrita", Hab_Escrita, m_act && wr_at(m_k));
    chk("ocupado", ocupado, m_act);
    chk("pronto", pronto, m_act && m_k == C * m_n + 2);
    chk("entrada", Entrada, m_data);
    if ((m_act && wr_at(m_k)) || !reset) chk("endereco", endereco, m_act ? (m_k - 1) / C - 1 : 0);
  end
  task automatic start();
    iniciar = 1;
    @(negedge clock);
    iniciar = 0;
  endtask
  task automatic wait_pronto(input string name, input int budget);
    bit fin = 0;
    for (int c = 0; c < budget && !fin; c++) begin
      @(negedge clock);
      fin = pronto;
    end
    chk(name, fin, 1);
  endtask
  // scrambles the seed/count inputs every cycle so only the latched values may matter
  task automatic run(input logic [31:0] s, input int n);
    int got = 0, nn = n == 0 ? 1 << AW : n;
    bit fin = 0;
    cap.delete();
    zero_seen = 0;
    semente = s;
    num_palavras = AW'(n);
    start();
    for (int c = 0; c < C * nn + 10 && !fin; c++) begin
      semente = $urandom;
      num_palavras = AW'($urandom);
      @(negedge clock);
      if (Hab_Escrita) begin
        chk("run_addr_seq", 64'(endereco), 64'(got));
        cap.push_back(Entrada);
        if (Entrada == '0) zero_seen = 1;
        got++;
      end
      fin = pronto;
    end
    chk("run_pronto_seen", fin, 1);
    chk("run_write_count", got, nn);
    @(negedge clock);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(negedge clock);
    chk("rst_hab", Hab_Escrita, 0);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_pronto", pronto, 0);
    chk("rst_endereco", endereco, 0);
    chk("rst_entrada", Entrada, 0);
    reset = 1;
    semente = 32'h0000_0001;
    num_palavras = 3;
    start();
    chk("seed_ocupado", ocupado, 1);
    semente = 32'hDEAD_BEEF;
    num_palavras = 7;
    repeat (9) @(negedge clock);
    chk("t10_hab", Hab_Escrita, 1);
    chk("t10_end", endereco, 0);
    chk("t10_data", Entrada, W0_SEED1);
    repeat (9) @(negedge clock);
    chk("t19_hab", Hab_Escrita, 1);
    chk("t19_end", endereco, 1);
    repeat (9) @(negedge clock);
    chk("t28_hab", Hab_Escrita, 1);
    chk("t28_end", endereco, 2);
    @(negedge clock);
    chk("t29_pronto", pronto, 1);
    @(negedge clock);
    chk("idle_ocupado", ocupado, 0);
    run(32'h0000_0001, 3);
    prev = cap;
    chk("run1_w0", cap[0], W0_SEED1);
    run(32'h0000_0001, 3);
    for (int i = 0; i < 3; i++) chk("same_seed_word", cap[i], prev[i]);
    semente = 32'h1357_9BDF;
    num_palavras = 5;
    start();
    repeat (4) @(negedge clock);
    #2 reset = 0;
    #1;
    chk("rst_mid_hab", Hab_Escrita, 0);
    chk("rst_mid_ocupado", ocupado, 0);
    chk("rst_mid_pronto", pronto, 0);
    chk("rst_mid_endereco", endereco, 0);
    chk("rst_mid_entrada", Entrada, 0);
    @(negedge clock);
    reset = 1;
    repeat (12) @(negedge clock);
    chk("rst_no_restart", ocupado, 0);
    semente = 32'h1234_5678;
    num_palavras = 2;
    iniciar = 1;
    wait_pronto("held_first_pronto", 40);
    @(negedge clock);
    chk("held_idle", ocupado, 0);
    @(negedge clock);
    chk("held_restart", ocupado, 1);
    iniciar = 0;
    wait_pronto("held_second_pronto", 40);
    @(negedge clock);
    run(32'hFFFF_FFFF, 64);
    chk("ffff_no_zero_word", zero_seen, 0);
    run(32'hA5A5_A5A5, 16);
`ifdef GERADOR_CODIGO_VALIDO_EN
    begin
      int n11 = 0;
      foreach (cap[i]) for (int f = 0; f < 32; f++) if (cap[i][2*f +: 2] == 2'b11) n11++;
      chk("no_reserved_code", n11, 0);
    end
`endif
    run(32'hC0FF_EE00, 0);
    chk("full_last_addr", endereco, {AW{1'b1}});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gerador_sequencia.md
GERADOR_SEQUENCIA -- requirements
Module: gerador_sequencia

Interface
REQ-001 Parameter bits_palavra, default 64: width of one generated word, 32 LEDs at 2 bits each.
REQ-002 Parameter end_registros, default 10: width of the data-memory address.
REQ-003 Parameter PASSOS, default 8: number of LFSR shift steps taken per generated word.
REQ-004 clock  input  1: single clock; all state changes on its rising edge.
REQ-005 reset  input  1: asynchronous, active-low reset.
REQ-006 iniciar  input  1: start request, sampled only in IDLE.
REQ-007 semente  input  32: seed, sampled in the cycle iniciar is accepted.
REQ-008 num_palavras  input  end_registros: word count; 0 means 2**end_registros words.
REQ-009 Hab_Escrita  output  1: memory write enable, high for exactly one cycle per word.
REQ-010 endereco  output  end_registros: memory write address.
REQ-011 Entrada  output  bits_palavra: memory write data.
REQ-012 ocupado  output  1: high from the cycle after acceptance until DONE is exited.
REQ-013 pronto  output  1: single-cycle completion pulse.

Function
REQ-014 The block SHALL implement the FSM states IDLE, SEED, GEN, WRITE and DONE.
REQ-015 IDLE: when iniciar=1, the block SHALL go to SEED and latch semente and num_palavras; otherwise it stays in IDLE.
REQ-016 SEED (1 cycle): lfsr SHALL be loaded with {semente, ~semente} (never all-zero), the word counter and endereco SHALL be cleared, and the block SHALL go to GEN.
REQ-017 GEN (PASSOS cycles): each cycle the block SHALL perform one Galois LFSR step with polynomial x^64+x^63+x^61+x^60+1, shifting right and XORing taps when the LSB is 1; it SHALL then go to WRITE.
REQ-018 WRITE (1 cycle): Hab_Escrita=1, endereco=counter and Entrada=lfsr (filtered per REQ-027) SHALL be driven in the same cycle.
REQ-019 After WRITE, if counter = count-1 the block SHALL go to DONE; otherwise the counter and endereco SHALL increment and the block SHALL return to GEN.
REQ-020 DONE (1 cycle): pronto=1 and then the block SHALL return to IDLE; ocupado SHALL fall on DONE exit.
REQ-021 Latency: from iniciar accepted at cycle t, the first Hab_Escrita SHALL occur at t+1+PASSOS+1, with successive writes every PASSOS+1 cycles and pronto at t+1+(PASSOS+1)*N+1.
REQ-022 iniciar asserted while not in IDLE SHALL be ignored, with no restart and no queuing.
REQ-023 Changes to semente and num_palavras after acceptance SHALL have no effect on the current run.
REQ-024 endereco SHALL never wrap within a run; the maximum written address is N-1, and N=2**end_registros ends at all-ones.
REQ-025 Hab_Escrita SHALL be low in every state other than WRITE; Entrada and endereco SHALL hold their last value outside WRITE.

Reset
REQ-026 While reset=0 the block SHALL be in IDLE with lfsr=0, counter=0, Hab_Escrita=0, endereco=0, Entrada=0, ocupado=0 and pronto=0, immediately and without waiting for clock; reset mid-run SHALL abort with no further writes.

Configuration
REQ-027 With macro GERADOR_CODIGO_VALIDO_EN defined, every 2-bit field of Entrada equal to 2'b11 (reserved LED code) SHALL be replaced by 2'b00; without the macro Entrada SHALL equal lfsr unmodified; lfsr state SHALL be identical in both builds.

Verification
REQ-028 Reset low mid-GEN of a run -> all outputs 0 in the same cycle; after release, iniciar is required to start again.
REQ-029 semente=32'h0000_0001, num_palavras=3, PASSOS=8 -> Hab_Escrita pulses at t+10, t+19 and t+28 with endereco 0, 1, 2, data matching the bit-accurate LFSR model, and pronto at t+29.
REQ-030 num_palavras=0 -> exactly 1024 writes, endereco 0..1023 with no gaps or repeats, then one pronto pulse.
REQ-031 iniciar held high for an entire run -> one run only; the block restarts in the cycle after returning to IDLE.
REQ-032 Same seed run twice -> identical Entrada sequences; semente=32'hFFFF_FFFF -> the LFSR is loaded nonzero and no word is all-zero before the 64th write.
REQ-033 GERADOR_CODIGO_VALIDO_EN defined, semente=32'hA5A5_A5A5, num_palavras=16 -> no 2'b11 field in any Entrada, and every field equals the model value with 11 mapped to 00.
